pt_check: RTL and testbench



---
 rtl/pt_check.sv | 97 +++++++++
 tb/tb_pt_check.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/pt_check.sv
// Printable-ASCII validator for the length-prefixed plaintext buffer written by arc4.
// Streams one byte per clock through a 1-cycle synchronous read port and reports ok/len/bad_idx.
module pt_check (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       en,
   output logic       rdy,
   output logic [7:0] pt_addr,
   input  logic [7:0] pt_rddata,
   output logic       ok,
   output logic [7:0] len,
   output logic [7:0] bad_idx
);

   // state | meaning
   // IDLE  | result valid, waiting for en
   // ADDR0 | mem[0] address presented, read in flight
   // LEN   | pt_rddata = mem[0]; latch length
   // SCAN  | pt_rddata = mem[idx]; check one character per cycle
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ADDR0 = 2'd1,
      S_LEN   = 2'd2,
      S_SCAN  = 2'd3
   } state_t;

   state_t     state;
   logic [7:0] idx;
   logic       printable;

   assign printable = (pt_rddata >= 8'h20) && (pt_rddata <= 8'h7E);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         rdy     <= 1'b1;
         pt_addr <= 8'd0;
         ok      <= 1'b0;
         len     <= 8'd0;
         bad_idx <= 8'd0;
         idx     <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               pt_addr <= 8'd0;
               if (en) begin
                  ok      <= 1'b0;
                  len     <= 8'd0;
                  bad_idx <= 8'd0;
                  rdy     <= 1'b0;
                  state   <= S_ADDR0;
               end
            end
            S_ADDR0: begin
               pt_addr <= 8'd1;
               state   <= S_LEN;
            end
            S_LEN: begin
               len <= pt_rddata;
               if (pt_rddata == 8'd0) begin
                  ok      <= 1'b1;
                  rdy     <= 1'b1;
                  pt_addr <= 8'd0;
                  state   <= S_IDLE;
               end else begin
                  idx     <= 8'd1;
                  pt_addr <= 8'd2;
                  state   <= S_SCAN;
               end
            end
            S_SCAN: begin
               if (!printable) begin
                  bad_idx <= idx;
                  ok      <= 1'b0;
                  rdy     <= 1'b1;
                  pt_addr <= 8'd0;
                  state   <= S_IDLE;
               end else if (idx == len) begin
                  ok      <= 1'b1;
                  rdy     <= 1'b1;
                  pt_addr <= 8'd0;
                  state   <= S_IDLE;
               end else begin
                  // address runs one ahead of idx; wraps 255->0 harmlessly at L=255
                  idx     <= idx + 8'd1;
                  pt_addr <= idx + 8'd2;
               end
            end
            default: begin
               state <= S_IDLE;
               rdy   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pt_check.sv
// Scoreboard bench for pt_check: stimulus pushes expected results from a reference model,
// a negedge monitor pops and compares whenever rdy rises.
module tb_pt_check;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en;
   logic       rdy;
   logic [7:0] pt_addr;
   logic [7:0] pt_rddata;
   logic       ok;
   logic [7:0] len;
   logic [7:0] bad_idx;

   logic [7:0] mem [256];
   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      int ok;
      int len;
      int bad;
      int start;
      int lat;
   } exp_t;

   exp_t q[$];

   pt_check dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .rdy       (rdy),
      .pt_addr   (pt_addr),
      .pt_rddata (pt_rddata),
      .ok        (ok),
      .len       (len),
      .bad_idx   (bad_idx)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      pt_rddata <= mem[pt_addr];
      cyc <= cyc + 1;
   end

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference: scan mem[1..L] for the first byte outside 0x20..0x7E.
   function automatic exp_t model(input int start);
      exp_t e;
      int   l;
      l = int'(mem[0]);
      e.ok = 1; e.len = l; e.bad = 0; e.lat = l + 2; e.start = start;
      for (int k = 1; k <= l; k++) begin
         if (mem[k] < 8'h20 || mem[k] > 8'h7E) begin
            e.ok = 0; e.bad = k; e.lat = k + 2;
            break;
         end
      end
      return e;
   endfunction

   initial begin : monitor
      bit   prev;
      exp_t e;
      prev = 1'b1;
      forever begin
         @(negedge clk);
         if (!rst_n) prev = 1'b1;
         else begin
            if (rdy && !prev) begin
               if (q.size() == 0) begin
                  tests++; fails++;
                  $display("FAIL spurious_done: got rdy rise with 0 pending expected 1 pending");
               end else begin
                  e = q.pop_front();
                  check("ok", int'(ok), e.ok);
                  check("len", int'(len), e.len);
                  check("bad_idx", int'(bad_idx), e.bad);
                  check("latency", cyc - e.start, e.lat);
               end
            end
            prev = rdy;
         end
      end
   end

   task automatic start_run();
      @(negedge clk);
      en = 1'b1;
      q.push_back(model(cyc + 1));
      @(negedge clk);
      en = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (q.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (q.size() != 0) begin
         tests++; fails++;
         $display("FAIL timeout: got %0d pending results expected 0", q.size());
         q.delete();
      end
      @(negedge clk);
   endtask

   task automatic load(input int l, input bit force_ok);
      mem[0] = 8'(l);
      for (int k = 1; k < 256; k++) mem[k] = 8'($urandom_range(32, 126));
      if (!force_ok && l > 0 && $urandom_range(0, 2) == 0) begin
         mem[$urandom_range(1, l)] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31))
                                                                   : 8'($urandom_range(127, 255));
      end
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      int n;
      for (int k = 0; k < 256; k++) mem[k] = 8'($urandom);
      rst_n = 1'b0;
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         en = 1'($urandom);
         mem[0] = 8'($urandom);
      end
      #1;
      check("rst_rdy", int'(rdy), 1);
      check("rst_ok", int'(ok), 0);
      check("rst_len", int'(len), 0);
      check("rst_bad_idx", int'(bad_idx), 0);
      check("rst_pt_addr", int'(pt_addr), 0);
      @(negedge clk);
      en = 1'b0;
      rst_n = 1'b1;

      // "Hello" with address sequence check
      mem[0] = 8'd5; mem[1] = 8'h48; mem[2] = 8'h65; mem[3] = 8'h6C; mem[4] = 8'h6C; mem[5] = 8'h6F;
      @(negedge clk);
      en = 1'b1;
      q.push_back(model(cyc + 1));
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         en = 1'b0;
         check("hello_pt_addr", int'(pt_addr), (j < 7) ? j : 0);
      end
      wait_idle();

      mem[0] = 8'd4; mem[1] = 8'h41; mem[2] = 8'h1F; mem[3] = 8'h42; mem[4] = 8'h43;
      start_run(); wait_idle();
      mem[0] = 8'd3; mem[1] = 8'h20; mem[2] = 8'h7E; mem[3] = 8'h41;
      start_run(); wait_idle();
      mem[0] = 8'd2; mem[1] = 8'h41; mem[2] = 8'h7F;
      start_run(); wait_idle();
      mem[0] = 8'd0; mem[1] = 8'h00;
      start_run(); wait_idle();
      mem[0] = 8'd255;
      for (int k = 1; k < 256; k++) mem[k] = 8'h61;
      start_run(); wait_idle();

      // en held high: second run begins the edge after rdy rises
      load(3, 1'b1);
      @(negedge clk);
      en = 1'b1;
      q.push_back(model(cyc + 1));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rdy && n < 300);
      check("hold_done_seen", int'(rdy), 1);
      q.push_back(model(cyc + 1));
      @(negedge clk);
      en = 1'b0;
      check("hold_restart_rdy", int'(rdy), 0);
      check("hold_restart_len_clear", int'(len), 0);
      wait_idle();

      // reset in the middle of a scan
      load(20, 1'b1);
      start_run();
      repeat (6) @(negedge clk);
      #2;
      rst_n = 1'b0;
      q.delete();
      #1;
      check("midrst_rdy", int'(rdy), 1);
      check("midrst_len", int'(len), 0);
      check("midrst_ok", int'(ok), 0);
      check("midrst_pt_addr", int'(pt_addr), 0);
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      load(9, 1'b0);
      start_run(); wait_idle();

      for (int t = 0; t < 30; t++) begin
         load($urandom_range(0, 40), 1'b0);
         start_run();
         wait_idle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
